// File: rtl/paddle_control.sv
// Tick-based paddle motion controller: reads A/D key state from KeyboardDecoder and
// produces the registered paddle x-position with acceleration and wall clamping.
module paddle_control #(
  parameter int TICK_CYCLES = 2_000_000,
  parameter int X_MIN       = 5,
  parameter int X_MAX       = 540,
  parameter int X_INIT      = 200,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 12,
  parameter int ACCEL_TICKS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic         enable,
  input  logic         recenter,
  output logic [9:0]   board_x,
  output logic [1:0]   move_dir,
  output logic [3:0]   step,
  output logic         at_wall,
  output logic         update
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [TW-1:0]   tcnt_r;
  logic [AW-1:0]   acnt_r;
  logic [AW-1:0]   acnt_s;
  logic [AW-1:0]   cur_acnt_s;
  logic [3:0]      step_r;
  logic [3:0]      step_s;
  logic [3:0]      cur_step_s;
  logic [9:0]      board_x_r;
  logic [9:0]      x_s;
  logic [10:0]     mv_x_s;
  logic [1:0]      move_dir_r;
  logic [1:0]      dir_s;
  logic            update_r;
  logic            upd_s;
  logic            tick_s;
  logic            key_l_s;
  logic            key_r_s;
  logic            moving_s;
  logic            go_left_s;
  logic            hit_wall_s;
  logic            unused_keys_s;

  // Only the A and D bits matter; the rest of the key map is folded away.
  assign unused_keys_s = ^{key_down[511:36], key_down[34:29], key_down[27:0]};

  assign tick_s  = (tcnt_r == TW'(TICK_CYCLES - 1));
  assign key_l_s = key_down[9'h01C];
  assign key_r_s = key_down[9'h023];

  // Wall-clamped move in 11 bits so board_x + step cannot wrap.
  function automatic logic [10:0] move_x(input logic [10:0] x, input logic [3:0] s,
                                         input logic go_left);
    logic [10:0] s11;
    logic [10:0] r;
    s11 = {7'b0000000, s};
    if (go_left) begin
      if (x < 11'(X_MIN) + s11) r = 11'(X_MIN);
      else                      r = x - s11;
    end else begin
      if (x + s11 > 11'(X_MAX)) r = 11'(X_MAX);
      else                      r = x + s11;
    end
    return r;
  endfunction

  // Next-state, step/acceleration and position update.
  always_comb begin
    state_s    = state_r;
    step_s     = step_r;
    acnt_s     = acnt_r;
    x_s        = board_x_r;
    upd_s      = 1'b0;
    cur_step_s = step_r;
    cur_acnt_s = acnt_r;
    moving_s   = 1'b0;
    go_left_s  = 1'b0;
    mv_x_s     = {1'b0, board_x_r};
    hit_wall_s = 1'b0;

    if (recenter) begin
      state_s = IDLE;
      step_s  = 4'(STEP_MIN);
      acnt_s  = {AW{1'b0}};
      x_s     = 10'(X_INIT);
      upd_s   = (board_x_r != 10'(X_INIT));
    end else if (!enable) begin
      state_s = IDLE;
      step_s  = 4'(STEP_MIN);
      acnt_s  = {AW{1'b0}};
    end else if (tick_s) begin
      if (key_l_s && !key_r_s) begin
        moving_s  = 1'b1;
        go_left_s = 1'b1;
        state_s   = MOVE_L;
        if (state_r != MOVE_L) begin
          cur_step_s = 4'(STEP_MIN);
          cur_acnt_s = {AW{1'b0}};
        end else begin
          cur_step_s = step_r;
          cur_acnt_s = acnt_r;
        end
      end else if (key_r_s && !key_l_s) begin
        moving_s  = 1'b1;
        go_left_s = 1'b0;
        state_s   = MOVE_R;
        if (state_r != MOVE_R) begin
          cur_step_s = 4'(STEP_MIN);
          cur_acnt_s = {AW{1'b0}};
        end else begin
          cur_step_s = step_r;
          cur_acnt_s = acnt_r;
        end
      end else begin
        state_s = IDLE;
        step_s  = 4'(STEP_MIN);
        acnt_s  = {AW{1'b0}};
      end
    end else begin
      state_s = state_r;
    end

    // A move that lands on its wall restarts acceleration from the minimum step.
    if (moving_s) begin
      mv_x_s     = move_x({1'b0, board_x_r}, cur_step_s, go_left_s);
      x_s        = mv_x_s[9:0];
      upd_s      = (mv_x_s[9:0] != board_x_r);
      hit_wall_s = go_left_s ? (mv_x_s == 11'(X_MIN)) : (mv_x_s == 11'(X_MAX));
      if (hit_wall_s) begin
        step_s = 4'(STEP_MIN);
        acnt_s = {AW{1'b0}};
      end else if (cur_acnt_s == AW'(ACCEL_TICKS - 1)) begin
        acnt_s = {AW{1'b0}};
        step_s = (cur_step_s >= 4'(STEP_MAX)) ? 4'(STEP_MAX) : cur_step_s + 4'd1;
      end else begin
        acnt_s = cur_acnt_s + AW'(1);
        step_s = cur_step_s;
      end
    end else begin
      mv_x_s = {1'b0, board_x_r};
    end
  end

  // Direction output encoding follows the next state.
  always_comb begin
    case (state_s)
      IDLE:    dir_s = 2'b00;
      MOVE_L:  dir_s = 2'b01;
      MOVE_R:  dir_s = 2'b10;
      default: dir_s = 2'b00;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt_r     <= {TW{1'b0}};
      state_r    <= IDLE;
      step_r     <= 4'(STEP_MIN);
      acnt_r     <= {AW{1'b0}};
      board_x_r  <= 10'(X_INIT);
      move_dir_r <= 2'b00;
      update_r   <= 1'b0;
    end else begin
      tcnt_r     <= tick_s ? {TW{1'b0}} : tcnt_r + TW'(1);
      state_r    <= state_s;
      step_r     <= step_s;
      acnt_r     <= acnt_s;
      board_x_r  <= x_s;
      move_dir_r <= dir_s;
      update_r   <= upd_s;
    end
  end

  assign board_x  = board_x_r;
  assign move_dir = move_dir_r;
  assign step     = step_r;
  assign update   = update_r;
  assign at_wall  = (board_x_r == 10'(X_MIN)) || (board_x_r == 10'(X_MAX));

endmodule

// File: tb/tb_paddle_control.sv
// Directed bench for paddle_control with a 4-cycle game tick: table of per-tick
// vectors plus hand sequences for ramps, wall hits and reset/recenter corners.
module tb_paddle_control;

  logic         clk;
  logic         rst;
  logic [511:0] key_down;
  logic         enable;
  logic         recenter;
  logic [9:0]   board_x;
  logic [1:0]   move_dir;
  logic [3:0]   step;
  logic         at_wall;
  logic         update;

  int checks = 0;
  int errors = 0;

  paddle_control #(.TICK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .enable(enable), .recenter(recenter),
    .board_x(board_x), .move_dir(move_dir), .step(step), .at_wall(at_wall), .update(update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic l; logic r; logic en; logic rc;
    int x; int dir; int stp; int upd; int wall;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic l, logic r, logic en, logic rc,
                              int x, int dir, int stp, int upd, int wall);
    vec_t v;
    v.l = l; v.r = r; v.en = en; v.rc = rc;
    v.x = x; v.dir = dir; v.stp = stp; v.upd = upd; v.wall = wall;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int x, input int dir, input int stp,
                         input int upd, input int wall);
    chk({tag, ".board_x"},  int'(board_x),  x);
    chk({tag, ".move_dir"}, int'(move_dir), dir);
    chk({tag, ".step"},     int'(step),     stp);
    chk({tag, ".update"},   int'(update),   upd);
    chk({tag, ".at_wall"},  int'(at_wall),  wall);
  endtask

  // Starts and ends #1 after a clock edge; the 4th edge is the tick edge.
  task automatic do_tick(input logic l, input logic r, input logic en, input logic rc);
    key_down         = '0;
    key_down[9'h01C] = l;
    key_down[9'h023] = r;
    enable           = en;
    repeat (3) @(posedge clk);
    #1 recenter = rc;
    @(posedge clk);
    #1 recenter = 1'b0;
  endtask

  task automatic hold(input logic l, input logic r, input int n);
    for (int k = 0; k < n; k++) do_tick(l, r, 1'b1, 1'b0);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      do_tick(tab[i].l, tab[i].r, tab[i].en, tab[i].rc);
      chk_all($sformatf("vec%0d", i), tab[i].x, tab[i].dir, tab[i].stp, tab[i].upd, tab[i].wall);
    end
  endtask

  initial begin
    // Table A: from x=200 idle (l, r, en, rc, x, dir, step, update, at_wall)
    tab.push_back(mk(0, 1, 1, 0, 202, 2, 2, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 204, 2, 3, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 207, 2, 3, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 210, 2, 4, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 214, 2, 4, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 218, 2, 5, 1, 0));
    tab.push_back(mk(1, 1, 1, 0, 218, 0, 2, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 218, 0, 2, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 200, 0, 2, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 202, 2, 2, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 204, 2, 3, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 207, 2, 3, 1, 0));
    tab.push_back(mk(1, 0, 1, 0, 205, 1, 2, 1, 0));
    tab.push_back(mk(1, 0, 1, 0, 203, 1, 3, 1, 0));
    tab.push_back(mk(0, 1, 0, 0, 203, 0, 2, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 203, 0, 2, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 205, 2, 2, 1, 0));
    tab.push_back(mk(0, 1, 1, 1, 200, 0, 2, 1, 0));
    tab.push_back(mk(0, 0, 1, 1, 200, 0, 2, 0, 0));
    // Table B: right wall approach from x=530 idle (index 19..)
    tab.push_back(mk(0, 1, 1, 0, 532, 2, 2, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 534, 2, 3, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 537, 2, 3, 1, 0));
    tab.push_back(mk(0, 1, 1, 0, 540, 2, 2, 1, 1));
    tab.push_back(mk(0, 1, 1, 0, 540, 2, 2, 0, 1));
    tab.push_back(mk(0, 1, 1, 0, 540, 2, 2, 0, 1));

    rst      = 1'b0;
    key_down = '0;
    key_down[9'h023] = 1'b1;
    enable   = 1'b1;
    recenter = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_all("reset", 200, 0, 2, 0, 0);

    // D held for 3 cycles then released before the tick edge: ignored.
    key_down = '0;
    key_down[9'h023] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("pre_tick.board_x", int'(board_x), 200);
    key_down = '0;
    @(posedge clk);
    #1 chk_all("d_between_ticks", 200, 0, 2, 0, 0);

    // Both keys pulsed between ticks only.
    key_down[9'h01C] = 1'b1;
    key_down[9'h023] = 1'b1;
    repeat (2) @(posedge clk);
    #1 key_down = '0;
    repeat (2) @(posedge clk);
    #1 chk_all("ad_between_ticks", 200, 0, 2, 0, 0);

    run_table(0, 19);

    // Left ramp into the wall: 25 ticks reach 10, the 26th clamps to 5.
    hold(1'b1, 1'b0, 25);
    chk("left_ramp.board_x", int'(board_x), 10);
    chk("left_ramp.step", int'(step), 12);
    do_tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("left_wall", 5, 1, 2, 1, 1);
    do_tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("left_wall_hold", 5, 1, 2, 0, 1);
    do_tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("recenter_from_wall", 200, 0, 2, 1, 0);

    // Ramp right to 298, then step once to 300 and recenter on a tick with D held.
    hold(1'b0, 1'b1, 17);
    chk("ramp298.board_x", int'(board_x), 298);
    chk("ramp298.step", int'(step), 10);
    hold(1'b0, 1'b0, 1);
    do_tick(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("x300", 300, 2, 2, 1, 0);
    @(posedge clk);
    #1 chk("update_one_cycle", int'(update), 0);
    chk("update_one_cycle.board_x", int'(board_x), 300);
    repeat (3) @(posedge clk);
    #1 do_tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk_all("recenter_at_300", 200, 0, 2, 1, 0);

    // Reach 530 exactly: 36 ticks to 522, then two short presses of two ticks.
    hold(1'b0, 1'b1, 36);
    chk("ramp522.board_x", int'(board_x), 522);
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 2);
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 2);
    hold(1'b0, 1'b0, 1);
    chk_all("at530", 530, 0, 2, 0, 0);
    run_table(19, 25);

    // Reset mid-period while moving; tick phase restarts from reset release.
    do_tick(1'b0, 1'b0, 1'b1, 1'b1);
    hold(1'b0, 1'b1, 2);
    chk("pre_reset.board_x", int'(board_x), 204);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk_all("mid_reset", 200, 0, 2, 0, 0);
    do_tick(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("after_mid_reset", 202, 2, 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
